// File: rtl/rgb_matrix_scan_driver.sv
// Column-scan driver for a COLS x ROWS RGB LED matrix: double-buffered frame, serial shift-out,
// latch, then a 16-slot dwell window. Define RGB_SCAN_BRIGHTNESS_EN for per-column PWM brightness.
module rgb_matrix_scan_driver #(
  parameter  int unsigned ROWS       = 8,
  parameter  int unsigned COLS       = 8,
  parameter  int unsigned CLK_DIV    = 4,
  parameter  int unsigned DWELL_SLOT = 1024,
  localparam int unsigned CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS*ROWS-1:0] frame_red,
  input  logic [COLS*ROWS-1:0] frame_green,
  input  logic [COLS*ROWS-1:0] frame_blue,
`ifdef RGB_SCAN_BRIGHTNESS_EN
  input  logic [3:0]           brightness,
`endif
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [CW-1:0]        col_num,
  output logic                 frame_start,
  output logic                 reset_out,
  output logic                 OE,
  output logic                 SH_CP,
  output logic                 ST_CP,
  output logic                 DS,
  output logic [COLS-1:0]      col_select
);

  localparam int unsigned FW       = COLS * ROWS;
  localparam int unsigned NBITS    = 3 * ROWS;
  localparam int unsigned BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned INIT_CYC = 4;
  localparam int unsigned CMAX0    = (CLK_DIV > DWELL_SLOT) ? CLK_DIV : DWELL_SLOT;
  localparam int unsigned CMAX     = (CMAX0 > INIT_CYC) ? CMAX0 : INIT_CYC;
  localparam int unsigned CNT_W    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_LOAD, S_SHIFT, S_LATCH, S_DWELL, S_BLANK
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              ph_q, ph_d;
  logic [3:0]        slot_q, slot_d;
  logic [CW-1:0]     col_q, col_d;
  logic [NBITS-1:0]  sreg_q, sreg_d;
  logic [FW-1:0]     act_r_q, act_g_q, act_b_q, act_r_d, act_g_d, act_b_d;
  logic [FW-1:0]     shd_r_q, shd_g_q, shd_b_q, shd_r_d, shd_g_d, shd_b_d;
  logic              shd_full_q, shd_full_d;
`ifdef RGB_SCAN_BRIGHTNESS_EN
  logic [3:0]        bright_q, bright_d;
`endif

  logic              transfer;
  logic              accept;
  logic              div_end;
  logic [FW-1:0]     src_r, src_g, src_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      bit_q      <= '0;
      ph_q       <= 1'b0;
      slot_q     <= '0;
      col_q      <= '0;
      sreg_q     <= '0;
      act_r_q    <= '0;
      act_g_q    <= '0;
      act_b_q    <= '0;
      shd_r_q    <= '0;
      shd_g_q    <= '0;
      shd_b_q    <= '0;
      shd_full_q <= 1'b0;
`ifdef RGB_SCAN_BRIGHTNESS_EN
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      slot_q     <= slot_d;
      col_q      <= col_d;
      sreg_q     <= sreg_d;
      act_r_q    <= act_r_d;
      act_g_q    <= act_g_d;
      act_b_q    <= act_b_d;
      shd_r_q    <= shd_r_d;
      shd_g_q    <= shd_g_d;
      shd_b_q    <= shd_b_d;
      shd_full_q <= shd_full_d;
`ifdef RGB_SCAN_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    slot_d     = slot_q;
    col_d      = col_q;
    sreg_d     = sreg_q;
    act_r_d    = act_r_q;
    act_g_d    = act_g_q;
    act_b_d    = act_b_q;
    shd_r_d    = shd_r_q;
    shd_g_d    = shd_g_q;
    shd_b_d    = shd_b_q;
    shd_full_d = shd_full_q;
`ifdef RGB_SCAN_BRIGHTNESS_EN
    bright_d   = bright_q;
`endif

    transfer = (state_q == S_LOAD) && (col_q == '0) && shd_full_q;
    accept   = frame_valid && frame_ready;
    div_end  = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Column 0 of a fresh frame is captured straight from the shadow in the transfer cycle.
    src_r = transfer ? shd_r_q : act_r_q;
    src_g = transfer ? shd_g_q : act_g_q;
    src_b = transfer ? shd_b_q : act_b_q;

    if (transfer) begin
      act_r_d    = shd_r_q;
      act_g_d    = shd_g_q;
      act_b_d    = shd_b_q;
      shd_full_d = 1'b0;
    end
    if (accept) begin
      shd_r_d    = frame_red;
      shd_g_d    = frame_green;
      shd_b_d    = frame_blue;
      shd_full_d = 1'b1;
    end

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        sreg_d  = {src_r[col_q*ROWS +: ROWS], src_g[col_q*ROWS +: ROWS], src_b[col_q*ROWS +: ROWS]};
        cnt_d   = '0;
        bit_d   = '0;
        ph_d    = 1'b0;
        state_d = S_SHIFT;
`ifdef RGB_SCAN_BRIGHTNESS_EN
        bright_d = brightness;
`endif
      end
      S_SHIFT: begin
        if (div_end) begin
          cnt_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d   = 1'b0;
            sreg_d = {sreg_q[NBITS-2:0], 1'b0};
            if (bit_q == BW'(NBITS - 1)) begin
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (div_end) begin
          cnt_d   = '0;
          slot_d  = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == CNT_W'(DWELL_SLOT - 1)) begin
          cnt_d = '0;
          if (slot_q == 4'd15) begin
            state_d = S_BLANK;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        state_d = S_LOAD;
        col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    frame_ready = (state_q != S_INIT) && !shd_full_q;
    frame_start = transfer;
    col_num     = col_q;
    reset_out   = (state_q != S_INIT);
    SH_CP       = (state_q == S_SHIFT) && ph_q;
    ST_CP       = (state_q == S_LATCH);
    DS          = (state_q == S_SHIFT) && sreg_q[NBITS-1];
    col_select  = '0;
    OE          = 1'b1;
    if ((state_q == S_LATCH) || (state_q == S_DWELL)) begin
      col_select = COLS'(1) << col_q;
    end
    if (state_q == S_DWELL) begin
`ifdef RGB_SCAN_BRIGHTNESS_EN
      OE = (slot_q >= bright_q);
`else
      OE = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_rgb_matrix_scan_driver.sv
// Self-checking bench for rgb_matrix_scan_driver; outputs are predicted cycle by cycle from the
// column timeline arithmetic and a two-slot (displayed/pending) frame model.
module tb_rgb_matrix_scan_driver;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CD    = 1;
  localparam int SLOT  = 2;
  localparam int FW    = ROWS * COLS;
  localparam int CW    = $clog2(COLS);
  localparam int INIT_LEN     = 4;
  localparam int SHIFT_LEN    = 2 * CD * 3 * ROWS;
  localparam int LATCH_LEN    = CD;
  localparam int DWELL_LEN    = 16 * SLOT;
  localparam int COL_PERIOD   = 1 + SHIFT_LEN + LATCH_LEN + DWELL_LEN + 1;
  localparam int FRAME_PERIOD = COL_PERIOD * COLS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] fr_r = '0, fr_g = '0, fr_b = '0;
  logic          fv = 1'b0;
  logic          frame_ready, frame_start, reset_out, OE, SH_CP, ST_CP, DS;
  logic [CW-1:0] col_num;
  logic [COLS-1:0] col_select;
`ifdef RGB_SCAN_BRIGHTNESS_EN
  logic [3:0]    bright = 4'd4;
`endif

  rgb_matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CD), .DWELL_SLOT(SLOT)
  ) u_dut (
    .clk(clk), .reset(reset),
    .frame_red(fr_r), .frame_green(fr_g), .frame_blue(fr_b),
`ifdef RGB_SCAN_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .frame_valid(fv), .frame_ready(frame_ready), .col_num(col_num),
    .frame_start(frame_start), .reset_out(reset_out), .OE(OE),
    .SH_CP(SH_CP), .ST_CP(ST_CP), .DS(DS), .col_select(col_select)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit            m_rst = 1'b1;
  int            t = 0;
  bit            m_pend = 1'b0;
  logic [FW-1:0] p_r = '0, p_g = '0, p_b = '0;
  logic [FW-1:0] d_r = '0, d_g = '0, d_b = '0;
  int            m_bright = 0;
  bit            auto_offer = 1'b0;
  int            last_fs = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input int col, input int b);
    int idx;
    idx = col * ROWS + (ROWS - 1 - (b % ROWS));
    case (b / ROWS)
      0:       return d_r[idx];
      1:       return d_g[idx];
      default: return d_b[idx];
    endcase
  endfunction

  task automatic check_outputs();
    int u, col, off, d;
    logic e_ro, e_oe, e_sh, e_st, e_ds, e_rdy, e_fs;
    logic [COLS-1:0] e_sel, one;
    int e_col;
    one = 1;
    e_ro = 0; e_oe = 1; e_sh = 0; e_st = 0; e_ds = 0; e_rdy = 0; e_fs = 0;
    e_sel = '0; e_col = 0;
    if (!m_rst && t >= INIT_LEN) begin
      u = t - INIT_LEN;
      col = (u / COL_PERIOD) % COLS;
      off = u % COL_PERIOD;
      e_ro = 1; e_col = col; e_rdy = !m_pend;
      e_fs = (off == 0 && col == 0 && m_pend);
      if (off >= 1 && off <= SHIFT_LEN) begin
        e_sh = ((off - 1) % (2 * CD)) >= CD;
        e_ds = exp_bit(col, (off - 1) / (2 * CD));
      end
      if (off > SHIFT_LEN && off <= SHIFT_LEN + LATCH_LEN) begin
        e_st  = 1;
        e_sel = one << col;
      end
      if (off > SHIFT_LEN + LATCH_LEN && off <= SHIFT_LEN + LATCH_LEN + DWELL_LEN) begin
        d = off - (SHIFT_LEN + LATCH_LEN + 1);
        e_sel = one << col;
`ifdef RGB_SCAN_BRIGHTNESS_EN
        e_oe = ((d / SLOT) < m_bright) ? 1'b0 : 1'b1;
`else
        e_oe = 1'b0;
`endif
      end
    end
    chk("reset_out",   32'(reset_out),   32'(e_ro));
    chk("OE",          32'(OE),          32'(e_oe));
    chk("SH_CP",       32'(SH_CP),       32'(e_sh));
    chk("ST_CP",       32'(ST_CP),       32'(e_st));
    chk("DS",          32'(DS),          32'(e_ds));
    chk("col_select",  32'(col_select),  32'(e_sel));
    chk("col_num",     32'(col_num),     32'(e_col));
    chk("frame_ready", 32'(frame_ready), 32'(e_rdy));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    if (frame_start === 1'b1 && auto_offer) begin
      if (last_fs >= 0) chk("frame_start_period", 32'(cyc - last_fs), 32'(FRAME_PERIOD));
      last_fs = cyc;
    end
  endtask

  task automatic drive();
    if (auto_offer && !fv && $urandom_range(0, 3) == 0) begin
      fr_r = {$urandom, $urandom};
      fr_g = {$urandom, $urandom};
      fr_b = {$urandom, $urandom};
      fv   = 1'b1;
    end
`ifdef RGB_SCAN_BRIGHTNESS_EN
    if ($urandom_range(0, 63) == 0) bright = 4'($urandom_range(0, 15));
`endif
  endtask

  task automatic advance();
    int u, col, off;
    bit acc;
    acc = 0;
    if (!m_rst && t >= INIT_LEN) begin
      u = t - INIT_LEN;
      col = (u / COL_PERIOD) % COLS;
      off = u % COL_PERIOD;
      if (off == 0 && col == 0 && m_pend) begin
        d_r = p_r; d_g = p_g; d_b = p_b;
        m_pend = 0;
      end else if (fv && !m_pend) begin
        p_r = fr_r; p_g = fr_g; p_b = fr_b;
        m_pend = 1;
        acc = 1;
      end
`ifdef RGB_SCAN_BRIGHTNESS_EN
      if (off == 0) m_bright = int'(bright);
`endif
    end
    @(negedge clk);
    cyc++;
    if (!m_rst) t++;
    if (acc) fv = 1'b0;
  endtask

  task automatic step();
    check_outputs();
    drive();
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    @(negedge clk);
    run(3);

    // Release reset; frame A is offered from the start and held off through INIT.
    reset = 1'b0; m_rst = 0; t = 0;
    fr_r = {$urandom, $urandom}; fr_g = {$urandom, $urandom}; fr_b = {$urandom, $urandom};
    fr_r[7:0] = 8'b1000_0001; fr_g[7:0] = 8'h00; fr_b[7:0] = 8'hFF;
    fv = 1'b1;
    run(2 * FRAME_PERIOD + 10);

    // Continuous random frames.
    auto_offer = 1; last_fs = -1;
    run(3 * FRAME_PERIOD);

    // Frame B mid-scan of column 3, then C held off until B is displayed.
    auto_offer = 0; fv = 1'b0;
    n = 0;
    while (!(col_num == CW'(3) && SH_CP === 1'b1 && frame_ready === 1'b1) && n < 3 * FRAME_PERIOD) begin
      step(); n++;
    end
    chk("wait_col3_shift", 32'({col_num, SH_CP, frame_ready}), 32'({CW'(3), 1'b1, 1'b1}));
    fr_r = {$urandom, $urandom}; fr_g = {$urandom, $urandom}; fr_b = {$urandom, $urandom};
    fv = 1'b1;
    step();
    fr_r = {$urandom, $urandom}; fr_g = {$urandom, $urandom}; fr_b = {$urandom, $urandom};
    fv = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME_PERIOD) begin
      step(); n++;
    end
    chk("wait_frame_start_B", 32'(frame_start), 32'(1));
    run(FRAME_PERIOD + 20);

    // Reset during SHIFT of column 5.
    n = 0;
    while (!(col_num == CW'(5) && SH_CP === 1'b1) && n < 2 * FRAME_PERIOD) begin
      step(); n++;
    end
    chk("wait_col5_shift", 32'({col_num, SH_CP}), 32'({CW'(5), 1'b1}));
    reset = 1'b1; m_rst = 1; m_pend = 0; fv = 1'b0;
    d_r = '0; d_g = '0; d_b = '0;
    #1;
    chk("midrst_OE",         32'(OE),         32'(1));
    chk("midrst_SH_CP",      32'(SH_CP),      32'(0));
    chk("midrst_col_select", 32'(col_select), 32'(0));
    chk("midrst_reset_out",  32'(reset_out),  32'(0));
    run(2);
    reset = 1'b0; m_rst = 0; t = 0; last_fs = -1;
    run(FRAME_PERIOD + 30);
    fr_r = {$urandom, $urandom}; fr_g = {$urandom, $urandom}; fr_b = {$urandom, $urandom};
    fv = 1'b1;
    run(2 * FRAME_PERIOD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
